// File: rtl/signal_ramp_envelope.sv
// signal_ramp_envelope
//   Per-channel amplitude envelope for the DAC path. Each channel watches its
//   own DDS phase stream and runs its own state machine; ramp edges start on
//   that channel's next phase wrap so every edge begins at zero phase. The
//   slope comes from a saturating fixed-point accumulator stepped by rampStep
//   every clock. Full scale is FS = 1<<FS_LOG2.
//
// Ports
//   clk                  clock
//   aresetn              synchronous, active-low reset
//   s_axis_tdata_phase   packed phase words, channel k at [k*PHASE_W +: PHASE_W]
//   s_axis_tvalid_phase  per-channel phase valid
//   enableRamping        0 forces every ramp output to FS (state machines keep running)
//   startRampUp          pulse: re-arm channels sitting in DONE, clears the down request
//   startRampDown        sets the sticky down request shared by all channels
//   rampStep             accumulator increment per clock, 0 = instant edge
//   ramp                 packed envelope values 0..FS, channel k at [k*OUT_W +: OUT_W]
//   rampState            packed 3-bit state codes, channel k at [k*3 +: 3]
//   rampDone             1 while the channel is in DONE
module signal_ramp_envelope #(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 48,
    parameter int FS_LOG2 = 13,
    parameter int FRAC_W  = 16,
    parameter int OUT_W   = 16
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic [N_CH*PHASE_W-1:0]     s_axis_tdata_phase,
    input  logic [N_CH-1:0]             s_axis_tvalid_phase,
    input  logic                        enableRamping,
    input  logic                        startRampUp,
    input  logic                        startRampDown,
    input  logic [FS_LOG2+FRAC_W-1:0]   rampStep,
    output logic [N_CH*OUT_W-1:0]       ramp,
    output logic [N_CH*3-1:0]           rampState,
    output logic [N_CH-1:0]             rampDone
);

    localparam int STEP_W = FS_LOG2 + FRAC_W;
    localparam int ACC_W  = STEP_W + 1;
    localparam logic [ACC_W-1:0] A_FS   = {1'b1, {STEP_W{1'b0}}};
    localparam logic [OUT_W-1:0] FS_OUT = OUT_W'(1) << FS_LOG2;

    typedef enum logic [2:0] {
        WAIT_UP   = 3'd0,
        UP        = 3'd1,
        HOLD      = 3'd2,
        WAIT_DOWN = 3'd3,
        DOWN      = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Shared sticky down request. startRampUp clears it in the same cycle it
    // is seen, but a simultaneous startRampDown wins and keeps it set, so
    // req_eff is what every channel acts on this cycle.
    logic down_req_reg;
    logic down_req_next;
    logic req_eff;

    always_comb begin
        req_eff       = startRampDown | (down_req_reg & ~startRampUp);
        down_req_next = req_eff;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            down_req_reg <= 1'b0;
        end else begin
            down_req_reg <= down_req_next;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [FS_LOG2-1:0] p;
        logic [FS_LOG2-1:0] p_prev_reg;
        logic               wrap;
        logic               unused_phase_low;
        logic [ACC_W-1:0]   acc_reg;
        logic [ACC_W-1:0]   acc_next;
        logic [ACC_W-1:0]   acc_up;
        logic [ACC_W-1:0]   acc_down;
        logic [ACC_W:0]     sum;
        state_t             state_reg;
        state_t             state_next;
        logic [OUT_W-1:0]   ramp_reg;
        logic [2:0]         state_code_reg;
        logic               done_reg;

        // Only the top FS_LOG2 phase bits matter for wrap detection.
        assign p                = s_axis_tdata_phase[gi*PHASE_W + PHASE_W - 1 -: FS_LOG2];
        assign unused_phase_low = ^s_axis_tdata_phase[gi*PHASE_W +: PHASE_W - FS_LOG2];
        assign wrap             = s_axis_tvalid_phase[gi] && (p < p_prev_reg);

        // Saturating step in both directions; a zero step means an instant edge.
        always_comb begin
            sum = {1'b0, acc_reg} + {2'b00, rampStep};
            if (rampStep == '0 || sum >= {1'b0, A_FS}) begin
                acc_up = A_FS;
            end else begin
                acc_up = sum[ACC_W-1:0];
            end
            if (rampStep == '0 || {1'b0, rampStep} >= acc_reg) begin
                acc_down = '0;
            end else begin
                acc_down = acc_reg - {1'b0, rampStep};
            end
        end

        // The cycle that enters UP or DOWN already applies that state's step,
        // so the first nonzero output appears 2 clocks after the wrap. The
        // end-of-ramp check uses the new acc value so state and acc stay aligned.
        always_comb begin
            state_next = state_reg;
            acc_next   = acc_reg;
            case (state_reg)
                WAIT_UP: begin
                    if (req_eff) begin
                        state_next = DONE;
                    end else if (wrap) begin
                        acc_next   = acc_up;
                        state_next = (acc_up == A_FS) ? HOLD : UP;
                    end
                end
                UP: begin
                    if (req_eff) begin
                        acc_next   = acc_down;
                        state_next = (acc_down == '0) ? DONE : DOWN;
                    end else begin
                        acc_next = acc_up;
                        if (acc_up == A_FS) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (req_eff) begin
                        state_next = WAIT_DOWN;
                    end
                end
                WAIT_DOWN: begin
                    if (wrap) begin
                        acc_next   = acc_down;
                        state_next = (acc_down == '0) ? DONE : DOWN;
                    end
                end
                DOWN: begin
                    acc_next = acc_down;
                    if (acc_down == '0) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (startRampUp && !req_eff) begin
                        state_next = WAIT_UP;
                    end
                end
                default: begin
                    state_next = WAIT_UP;
                    acc_next   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!aresetn) begin
                p_prev_reg     <= '0;
                acc_reg        <= '0;
                state_reg      <= WAIT_UP;
                ramp_reg       <= enableRamping ? '0 : FS_OUT;
                state_code_reg <= WAIT_UP;
                done_reg       <= 1'b0;
            end else begin
                if (s_axis_tvalid_phase[gi]) begin
                    p_prev_reg <= p;
                end
                acc_reg        <= acc_next;
                state_reg      <= state_next;
                // Output register: shows the acc value one clock after it is written.
                ramp_reg       <= enableRamping ? OUT_W'(acc_reg[ACC_W-1:FRAC_W]) : FS_OUT;
                state_code_reg <= state_reg;
                done_reg       <= (state_reg == DONE);
            end
        end

        assign ramp[gi*OUT_W +: OUT_W] = ramp_reg;
        assign rampState[gi*3 +: 3]    = state_code_reg;
        assign rampDone[gi]            = done_reg;
    end

endmodule

// File: tb/tb_signal_ramp_envelope.sv
// Directed bench for signal_ramp_envelope: ramp-up, wrap-aligned ramp-down,
// channel independence, abort, zero-step edges, bypass, re-arm and reset.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_signal_ramp_envelope;
    localparam int N_CH    = 4;
    localparam int PHASE_W = 48;
    localparam int FS_LOG2 = 13;
    localparam int FRAC_W  = 16;
    localparam int OUT_W   = 16;
    localparam int FS      = 8192;
    localparam int IDLE_P  = 100;

    localparam int S_WAIT_UP = 0, S_UP = 1, S_HOLD = 2, S_WAIT_DOWN = 3, S_DOWN = 4, S_DONE = 5;

    logic                      clk = 1'b0;
    logic                      aresetn;
    logic [N_CH*PHASE_W-1:0]   tdata;
    logic [N_CH-1:0]           tvalid;
    logic                      en;
    logic                      up;
    logic                      down;
    logic [FS_LOG2+FRAC_W-1:0] step;
    logic [N_CH*OUT_W-1:0]     ramp;
    logic [N_CH*3-1:0]         ramp_state;
    logic [N_CH-1:0]           ramp_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    signal_ramp_envelope #(
        .N_CH(N_CH), .PHASE_W(PHASE_W), .FS_LOG2(FS_LOG2), .FRAC_W(FRAC_W), .OUT_W(OUT_W)
    ) dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .s_axis_tdata_phase (tdata),
        .s_axis_tvalid_phase(tvalid),
        .enableRamping      (en),
        .startRampUp        (up),
        .startRampDown      (down),
        .rampStep           (step),
        .ramp               (ramp),
        .rampState          (ramp_state),
        .rampDone           (ramp_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r(input int ch);
        return 32'(ramp[ch*OUT_W +: OUT_W]);
    endfunction

    function automatic logic [31:0] st(input int ch);
        return 32'(ramp_state[ch*3 +: 3]);
    endfunction

    function automatic logic [31:0] dn(input int ch);
        return 32'(ramp_done[ch]);
    endfunction

    task automatic set_p(input int ch, input int val);
        tdata[ch*PHASE_W +: PHASE_W] = PHASE_W'(val) << (PHASE_W - FS_LOG2);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        aresetn = 1'b0;
        en      = 1'b1;
        up      = 1'b0;
        down    = 1'b0;
        step    = 1 << FRAC_W;
        tvalid  = '1;
        tdata   = '0;
        for (int c = 0; c < N_CH; c++) set_p(c, IDLE_P);

        // Reset state
        tick(); tick();
        check("reset_ramp", 32'(ramp), 0);
        check("reset_state", 32'(ramp_state), 0);
        check("reset_done", 32'(ramp_done), 0);
        aresetn = 1'b1;
        tick();   // every channel with tvalid latches p = IDLE_P

        // Ramp-up: ch0 wraps now, ch1 100 cycles later, ch2 has tvalid=0.
        set_p(0, 0);
        tvalid[2] = 1'b0;
        for (int t = 1; t <= 8300; t++) begin
            tick();
            if (t == 1)   set_p(0, IDLE_P);
            if (t == 100) set_p(1, 0);
            if (t == 101) set_p(1, IDLE_P);
            set_p(2, (t % 2 == 0) ? 0 : IDLE_P);
            if (t == 1) check("up_r0_t1", r(0), 0);
            if (t == 2) begin
                check("up_r0_t2", r(0), 1);
                check("up_st0_t2", st(0), S_UP);
            end
            if (t == 3) check("up_r0_t3", r(0), 2);
            if (t == 500) begin
                check("up_r0_t500", r(0), 499);
                check("lag_r1_t500", r(1), 399);
                check("novalid_r2", r(2), 0);
                check("novalid_st2", st(2), S_WAIT_UP);
            end
            if (t == 8192) check("up_r0_last", r(0), 8191);
            if (t == 8193) begin
                check("up_r0_fs", r(0), FS);
                check("up_st0_hold", st(0), S_HOLD);
                check("lag_r1_t8193", r(1), 8092);
            end
            if (t == 8300) begin
                check("hold_r1", r(1), FS);
                check("hold_st1", st(1), S_HOLD);
                check("idle_st3", st(3), S_WAIT_UP);
            end
        end

        // Ramp-down waits for ch0's next wrap (37 cycles after the request).
        down = 1'b1;
        for (int s = 1; s <= 8232; s++) begin
            tick();
            if (s == 1)  down = 1'b0;
            if (s == 37) set_p(0, 0);
            if (s == 38) set_p(0, IDLE_P);
            if (s == 2) begin
                check("dn_st0_wait", st(0), S_WAIT_DOWN);
                check("dn_r0_wait", r(0), FS);
                check("dn_st2_done", st(2), S_DONE);
                check("dn_done2", dn(2), 1);
                check("dn_done0_early", dn(0), 0);
            end
            if (s == 38) check("dn_r0_atwrap", r(0), FS);
            if (s == 39) check("dn_r0_first", r(0), FS - 1);
            if (s == 40) check("dn_r0_second", r(0), FS - 2);
            if (s == 8229) begin
                check("dn_r0_one", r(0), 1);
                check("dn_st0_down", st(0), S_DOWN);
            end
            if (s == 8230) begin
                check("dn_r0_zero", r(0), 0);
                check("dn_st0_done", st(0), S_DONE);
                check("dn_done0", dn(0), 1);
                check("dn_st1_waitdn", st(1), S_WAIT_DOWN);
            end
        end

        // Re-arm from DONE, ramp up, then abort while ramp0 = 3000.
        up = 1'b1;
        for (int u = 1; u <= 6005; u++) begin
            tick();
            if (u == 1) up = 1'b0;
            if (u == 2) begin
                check("rearm_st0", st(0), S_WAIT_UP);
                set_p(0, 0);
            end
            if (u == 3) set_p(0, IDLE_P);
            if (u == 1000) check("rearm_r0", r(0), 997);
            if (u == 3003) begin
                check("abort_r0_3000", r(0), 3000);
                down = 1'b1;
            end
            if (u == 3004) begin
                down = 1'b0;
                check("abort_r0_peak", r(0), 3001);
                check("abort_st0_up", st(0), S_UP);
            end
            if (u == 3005) begin
                check("abort_r0_rev", r(0), 3000);
                check("abort_st0_down", st(0), S_DOWN);
            end
            if (u == 3006) check("abort_r0_2999", r(0), 2999);
            if (u == 6005) begin
                check("abort_r0_zero", r(0), 0);
                check("abort_st0_done", st(0), S_DONE);
            end
        end

        // startRampUp together with startRampDown: down wins, ch0 stays DONE.
        up = 1'b1; down = 1'b1;
        tick(); up = 1'b0; down = 1'b0;
        tick(); tick();
        check("both_st0_done", st(0), S_DONE);
        // Re-arm alone, then instant edges with rampStep = 0.
        up = 1'b1; step = '0;
        tick(); up = 1'b0;
        tick();
        check("step0_st0_wait", st(0), S_WAIT_UP);
        set_p(0, 0);
        tick(); set_p(0, IDLE_P);
        check("step0_r0_pre", r(0), 0);
        tick();
        check("step0_r0_fs", r(0), FS);
        check("step0_st0_hold", st(0), S_HOLD);

        // Bypass: outputs forced to FS while the state machines keep running.
        tick(); en = 1'b0;
        tick();
        check("byp_r0", r(0), FS);
        check("byp_r2", r(2), FS);
        down = 1'b1;
        tick(); down = 1'b0;
        tick(); set_p(0, 0);
        tick(); set_p(0, IDLE_P);
        tick();
        check("byp_st0_done", st(0), S_DONE);
        check("byp_r0_forced", r(0), FS);
        en = 1'b1;
        tick();
        check("reen_r0", r(0), 0);

        // Ramp-down on ch1 then reset mid-DOWN.
        step = 1 << FRAC_W;
        tick(); set_p(1, 0);
        tick(); set_p(1, IDLE_P);
        tick();
        check("rst_r1_down", r(1), FS - 1);
        check("rst_st1_down", st(1), S_DOWN);
        aresetn = 1'b0;
        tick(); aresetn = 1'b1;
        check("rst_ramp", 32'(ramp), 0);
        check("rst_state", 32'(ramp_state), 0);
        check("rst_done", 32'(ramp_done), 0);
        tick();
        check("rst_st1_after", st(1), S_WAIT_UP);
        check("rst_r1_after", r(1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
